// File: rtl/reg_dump_ctrl_if.sv
// reg_dump_ctrl_if: word stream leaving the register dump sequencer.
//   out_data  - captured register word
//   out_addr  - register index of the word on out_data
//   out_valid - a word is presented
//   out_ready - consumer can take the word
//   out_last  - the presented word is the final word of the dump
// Handshake: a word transfers on a rising edge where out_valid=1 and
// out_ready=1. While out_valid=1 and out_ready=0 the master keeps
// out_data/out_addr/out_last stable; out_ready while out_valid=0 is ignored.
interface reg_dump_ctrl_if #(
    parameter int DW = 16,
    parameter int AW = 3
) ();
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    modport master (
        output out_data,
        output out_addr,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_addr,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl: read-side sequencer for a 2^AW x DW register file.
// On start it walks rd_addr from first_addr to last_addr (wrapping modulo
// 2^AW), captures each word once and presents it on the dump stream with
// its register index. One bubble cycle per word (READ between words).
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   start      - one-cycle dump request, only honoured in IDLE
//   first_addr - first index to dump (sampled on accepted start)
//   last_addr  - last index to dump (sampled on accepted start)
//   rd_addr    - registered read address to the register file
//   rd_data    - combinational read data from the register file
//   dump       - word stream (reg_dump_ctrl_if master)
//   busy       - high in READ and HOLD
//   done       - one-cycle pulse after the final word is accepted
//   word_count - words accepted in the current/last dump
//   state_dbg  - current FSM state (IDLE=0, READ=1, HOLD=2, DONE=3)
module reg_dump_ctrl #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [AW-1:0]         first_addr,
    input  logic [AW-1:0]         last_addr,
    output logic [AW-1:0]         rd_addr,
    input  logic [DW-1:0]         rd_data,
    reg_dump_ctrl_if.master       dump,
    output logic                  busy,
    output logic                  done,
    output logic [AW:0]           word_count,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] cur;
    logic [AW-1:0] end_addr;
    logic          handshake;

    assign handshake = dump.out_valid && dump.out_ready;
    assign state_dbg = state;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = READ;
            READ: state_next = HOLD;
            HOLD: if (handshake) state_next = dump.out_last ? DONE : READ;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decoded outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            READ, HOLD: busy = 1'b1;
            DONE:       done = 1'b1;
            default: ;
        endcase
    end

    // Datapath. The word is captured once at the end of READ, so register
    // file writes during HOLD cannot disturb the presented word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur            <= '0;
            end_addr       <= '0;
            rd_addr        <= '0;
            word_count     <= '0;
            dump.out_data  <= '0;
            dump.out_addr  <= '0;
            dump.out_valid <= 1'b0;
            dump.out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cur        <= first_addr;
                        end_addr   <= last_addr;
                        rd_addr    <= first_addr;
                        word_count <= '0;
                    end
                end
                READ: begin
                    dump.out_data  <= rd_data;
                    dump.out_addr  <= cur;
                    dump.out_last  <= (cur == end_addr);
                    dump.out_valid <= 1'b1;
                end
                HOLD: begin
                    if (handshake) begin
                        dump.out_valid <= 1'b0;
                        dump.out_last  <= 1'b0;
                        word_count     <= word_count + 1'b1;
                        if (!dump.out_last) begin
                            // Index wraps naturally through AW-bit truncation.
                            cur     <= cur + 1'b1;
                            rd_addr <= cur + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
module tb_reg_dump_ctrl;

    localparam int DW = 16;
    localparam int AW = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          start;
    logic [AW-1:0] first;
    logic [AW-1:0] last;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic [AW:0]   word_count;
    logic [1:0]    state_dbg;

    reg_dump_ctrl_if #(.DW(DW), .AW(AW)) dif ();

    // Register file model: combinational read port.
    logic [DW-1:0] rf [8];
    assign rd_data = rf[rd_addr];

    reg_dump_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .first_addr (first),
        .last_addr  (last),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .dump       (dif.master),
        .busy       (busy),
        .done       (done),
        .word_count (word_count),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    // Entry: {out_last, out_addr, out_data}
    logic [DW+AW:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_hs_cyc = -1;
    int done_seen = 0;
    int bp = 0;
    int wait_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- ready driver ----------------
    // bp=0: out_ready held high. bp>0: each word is refused for bp cycles.
    initial begin
        dif.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bp == 0) begin
                dif.out_ready = 1'b1;
            end else if (dif.out_valid) begin
                if (wait_cnt < bp) begin
                    dif.out_ready = 1'b0;
                    wait_cnt++;
                end else begin
                    dif.out_ready = 1'b1;
                    wait_cnt = 0;
                end
            end else begin
                dif.out_ready = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    // Checks the presented word against the queue head every cycle it is
    // valid (stability under backpressure), pops on handshake.
    always @(negedge clk) begin
        if (reset) begin
            if (done) done_seen++;
            if (dif.out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h expected none",
                             {dif.out_last, dif.out_addr, dif.out_data});
                end else begin
                    check("word", 32'({dif.out_last, dif.out_addr, dif.out_data}), 32'(exp_q[0]));
                    if (dif.out_ready) begin
                        void'(exp_q.pop_front());
                        last_hs_cyc = cyc + 1;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_exp(input logic [AW-1:0] f, input logic [AW-1:0] l);
        logic [AW-1:0] a;
        int n;
        n = int'(3'(l - f)) + 1;
        a = f;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(a == l), a, rf[a]});
            a = a + 1'b1;
        end
    endtask

    task automatic run_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
        @(posedge clk);
        #1;
        start = 1'b1;
        first = f;
        last  = l;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_valid_low", 32'(dif.out_valid), 32'd0);
        check("start_count_clear", 32'(word_count), 32'd0);
        check("start_rd_addr", 32'(rd_addr), 32'(f));
        @(posedge clk);
        #1;
        check("first_valid_latency", 32'(dif.out_valid), 32'd1);
    endtask

    task automatic wait_done(input int n, input bit start_in_done);
        int d0;
        bit seen;
        d0 = done_seen;
        seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("word_count", 32'(word_count), 32'(n));
            check("queue_empty", 32'(exp_q.size()), 32'd0);
            check("done_after_hs", 32'(cyc), 32'(last_hs_cyc));
            if (start_in_done) begin
                start = 1'b1;
                first = 3'd0;
                last  = 3'd0;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            @(negedge clk);
            #1;
            check("done_one_cycle", 32'(done), 32'd0);
            check("idle_after_done", 32'(busy), 32'd0);
            check("done_pulses", 32'(done_seen - d0), 32'd1);
        end
        exp_q.delete();
    endtask

    task automatic wait_word(input logic [AW-1:0] a);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (dif.out_valid && dif.out_addr == a) begin
                seen = 1'b1;
                break;
            end
        end
        check("word_reached", 32'(seen), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd_addr"},    32'(rd_addr), 32'd0);
        check({tag, "_out_data"},   32'(dif.out_data), 32'd0);
        check({tag, "_out_addr"},   32'(dif.out_addr), 32'd0);
        check({tag, "_out_valid"},  32'(dif.out_valid), 32'd0);
        check({tag, "_out_last"},   32'(dif.out_last), 32'd0);
        check({tag, "_busy"},       32'(busy), 32'd0);
        check({tag, "_done"},       32'(done), 32'd0);
        check({tag, "_word_count"}, 32'(word_count), 32'd0);
        check({tag, "_state"},      32'(state_dbg), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    initial begin
        int d0;
        reset = 1'b0;
        start = 1'b0;
        first = '0;
        last  = '0;
        for (int i = 0; i < 8; i++) rf[i] = 16'h1000 + 16'(i);

        // 1: reset, then full dump 0..7 with out_ready held high
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        bp = 0;
        push_exp(3'd0, 3'd7);
        run_start(3'd0, 3'd7);
        wait_done(8, 1'b0);

        // 2: wrap-around 6..1
        push_exp(3'd6, 3'd1);
        run_start(3'd6, 3'd1);
        wait_done(4, 1'b0);

        // 3: single word, plus a start in the done cycle that must be ignored
        push_exp(3'd3, 3'd3);
        run_start(3'd3, 3'd3);
        wait_done(1, 1'b1);

        // 4: backpressure, 5 refused cycles per word
        bp = 5;
        push_exp(3'd0, 3'd7);
        run_start(3'd0, 3'd7);
        wait_done(8, 1'b0);
        bp = 0;

        // 5a: start re-pulsed while busy is ignored
        push_exp(3'd0, 3'd7);
        run_start(3'd0, 3'd7);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        first = 3'd5;
        last  = 3'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(8, 1'b0);

        // 5b: asynchronous reset mid-dump, then a fresh dump
        push_exp(3'd0, 3'd7);
        run_start(3'd0, 3'd7);
        wait_word(3'd3);
        d0 = done_seen;
        #1;
        reset = 1'b0;
        #1;
        check_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        check("midreset_no_done", 32'(done_seen - d0), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        push_exp(3'd4, 3'd6);
        run_start(3'd4, 3'd6);
        wait_done(3, 1'b0);

        // 6: register write during HOLD does not change the presented word
        bp = 5;
        push_exp(3'd1, 3'd3);
        run_start(3'd1, 3'd3);
        wait_word(3'd2);
        rf[2] = 16'hBEEF;
        wait_done(3, 1'b0);
        rf[2] = 16'h1002;
        bp = 0;

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
